// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : count_seq_ctrl
//  Purpose  : Sequencer for a shared up-counter. Loads a start value, advances
//             the count every presc+1 cycles, and supports pause, stop,
//             one-shot and auto-reload operation. Drives the terminal flag t
//             (count all-ones) for the downstream counter checker.
//  Ports    : clk         - clock, rising edge
//             reset       - asynchronous reset, active low
//             start       - begin a sequence (accepted in IDLE only)
//             stop        - abort to IDLE, highest priority
//             pause       - level, freezes counting while high in RUN
//             load_val    - start/reload value, latched on accepted start
//             presc       - prescale divider, latched on accepted start
//             auto_reload - 1 = reload at terminal, 0 = one-shot
//             count       - registered count value
//             t           - high iff count == MAX
//             busy        - high in RUN or PAUSE
//             done        - one-cycle pulse per terminal event
//  Revision : 1.0 - initial release
// ============================================================================
module count_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc,
    input  logic               auto_reload,
    output logic [WIDTH-1:0]   count,
    output logic               t,
    output logic               busy,
    output logic               done
);

    localparam logic [WIDTH-1:0] C_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [WIDTH-1:0]   r_count, w_count;
    logic [PRESC_W-1:0] r_pc,    w_pc;
    logic [WIDTH-1:0]   r_load,  w_load;
    logic [PRESC_W-1:0] r_presc, w_presc;
    logic               r_auto,  w_auto;
    logic               r_done,  w_done;
    logic               w_tick;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_pc    <= '0;
            r_load  <= '0;
            r_presc <= '0;
            r_auto  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_count <= w_count;
            r_pc    <= w_pc;
            r_load  <= w_load;
            r_presc <= w_presc;
            r_auto  <= w_auto;
            r_done  <= w_done;
        end
    end

    // Prescaler rollover: the count moves on the edge where pc reaches the
    // latched divider, so the first advance lands presc+1 edges after start.
    assign w_tick = (r_pc == r_presc);

    // ------------------------------------------------------------------------
    // Next-state / datapath logic. Priority: stop > pause > start/tick.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_pc    = r_pc;
        w_load  = r_load;
        w_presc = r_presc;
        w_auto  = r_auto;
        w_done  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load  = load_val;
                    w_presc = presc;
                    w_auto  = auto_reload;
                    w_count = load_val;
                    w_pc    = '0;
                    w_state = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    w_pc    = '0;
                    w_state = S_IDLE;
                end else if (pause) begin
                    // Freeze everything; no tick is taken on this edge.
                    w_state = S_PAUSE;
                end else if (w_tick) begin
                    w_pc = '0;
                    if (r_count == C_MAX) begin
                        w_done = 1'b1;
                        if (r_auto) begin
                            w_count = r_load;
                        end else begin
                            w_state = S_DONE;
                        end
                    end else begin
                        w_count = r_count + WIDTH'(1);
                    end
                end else begin
                    w_pc = r_pc + PRESC_W'(1);
                end
            end

            S_PAUSE: begin
                if (stop) begin
                    w_pc    = '0;
                    w_state = S_IDLE;
                end else if (!pause) begin
                    // pc is kept so the interrupted prescale period resumes.
                    w_state = S_RUN;
                end
            end

            S_DONE: begin
                w_pc    = '0;
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign count = r_count;
    assign t     = (r_count == C_MAX);
    assign busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Controller that sequences a shared up-counter: it loads a start value, advances the count at a programmable prescaled rate, and supports pause, stop, one-shot and auto-reload operation. It drives the terminal flag t, defined as asserted exactly when count is all-ones. It sits in front of the counter-checker assertion module, which observes its count/t outputs unchanged.

Parameters:
WIDTH, 4, counter width; MAX = 2^WIDTH-1
PRESC_W, 8, prescaler field width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
start  input  1  begin sequence; sampled only in IDLE
stop  input  1  abort to IDLE; highest priority
pause  input  1  level; freezes counting while high in RUN
load_val  input  WIDTH  start/reload value, latched on accepted start
presc  input  PRESC_W  divider; count advances every presc+1 cycles; latched on start
auto_reload  input  1  1 = reload and continue at terminal, 0 = one-shot; latched on start
count  output  WIDTH  current count value (registered)
t  output  1  high iff count == MAX, in every state
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse per terminal event

Behaviour:
- Async reset (reset=0): state=IDLE, count=0, prescaler counter pc=0, latched cfg=0, busy=0, done=0, t=0. Applies immediately, including mid-RUN/PAUSE. Operation resumes on the first rising clk edge after reset deasserts.
- Invariant: t == (count == MAX) on every cycle, including IDLE and DONE.
- States: IDLE, RUN, PAUSE, DONE. Priority on each edge: stop > pause > start/tick.
- IDLE: stop has no effect. start=1 at edge N latches load_val/presc/auto_reload, count<=load_val, pc<=0, state<=RUN. busy=1 from after edge N. Count holds otherwise.
- RUN: tick = (pc == presc_l). On a tick, pc<=0 and count advances. Otherwise pc<=pc+1. With presc=0, count advances every edge. The first advance is presc_l+1 edges after the start edge. start is ignored in RUN.
- Terminal event = tick while count==MAX.
  - auto_reload_l=1: count<=load_l, stay in RUN, done=1 for the next cycle.
  - auto_reload_l=0: count holds MAX, state<=DONE, done=1 for the next cycle.
- Non-terminal tick: count<=count+1. No wrap occurs outside the terminal rule.
- pause=1 in RUN: state<=PAUSE; count and pc frozen; no tick on that edge. In PAUSE, pause=0 returns to RUN with pc preserved, and ticking resumes on the following edges.
- stop=1 in RUN/PAUSE/DONE: state<=IDLE, count held, pc<=0, done not asserted. stop with a simultaneous terminal tick: stop wins, no done pulse.
- DONE: lasts one cycle, then unconditionally goes to IDLE. start during DONE is ignored. busy=0 in DONE.
- load_val==MAX at start: t=1 on the first RUN cycle. The terminal event fires on the first tick.
- Input changes to load_val/presc/auto_reload after start have no effect until the next accepted start.
- done is registered. It is high exactly one cycle after the edge that took the terminal tick, and is never high in consecutive cycles unless presc=0 and auto_reload with load_val==MAX.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> count=0, t=0, busy=0, done=0. Assert reset=0 mid-RUN at count=7 -> all outputs return to reset values immediately, without waiting for a clock edge.
- One-shot, presc=0, load_val=12, start for 1 cycle -> count 12,13,14,15 on successive cycles. t=1 only at 15. done=1 one cycle later, with count holding 15, busy=0. Then IDLE.
- Prescale: presc=2, load_val=0 -> count increments every 3 cycles. Check 14->15 spacing is 3 cycles, and t=0 whenever count<15 throughout.
- Auto-reload: presc=0, load_val=13, auto_reload=1 -> sequence 13,14,15,13,14,15 with a done pulse after each 15. busy stays 1.
- Pause/stop: presc=1, pause=1 for 5 cycles at count=5 -> count and pc frozen, state PAUSE, busy=1. Resume with pause=0, then assert stop on the edge of the terminal tick at 15 -> IDLE, count=15, t=1, no done pulse.
- Start in RUN and load_val=15 at start: a second start mid-run is ignored. Starting with load_val=15 gives t=1 immediately and done after presc+1 cycles.
